seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 103 ++++++++++
 tb/tb_seg_scan.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner: ON/BLANK time slicing per digit, per-scan
// input snapshot, leading-zero suppression and active-low anode/decimal-point drives.
module seg_scan #(
   parameter int unsigned ON_CYCLES    = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] value_i,
   input  logic [3:0]  digit_en_i,
   input  logic [3:0]  dp_i,
   input  logic        lz_i,
   output logic [3:0]  hex_o,
   output logic [3:0]  an_o,
   output logic        dp_o,
   output logic [1:0]  idx_o
);

   localparam int unsigned MaxCyc = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
   localparam int unsigned CntW   = $clog2(MaxCyc + 1);

   typedef enum logic {StOn, StBlank} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic              capture;

   logic [15:0]       snap_value_q;
   logic [3:0]        snap_en_q;
   logic [3:0]        snap_dp_q;
   logic              snap_lz_q;

   logic [3:0]        supp;
   logic              lit;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StBlank;
         cnt_q        <= '0;
         idx_q        <= 2'd3;
         snap_value_q <= '0;
         snap_en_q    <= '0;
         snap_dp_q    <= '0;
         snap_lz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         if (capture) begin
            snap_value_q <= value_i;
            snap_en_q    <= digit_en_i;
            snap_dp_q    <= dp_i;
            snap_lz_q    <= lz_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CntW'(1);
      idx_d   = idx_q;
      capture = 1'b0;
      unique case (state_q)
         StOn: begin
            if (cnt_q == CntW'(ON_CYCLES - 1)) begin
               state_d = StBlank;
               cnt_d   = '0;
            end
         end
         StBlank: begin
            if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
               state_d = StOn;
               cnt_d   = '0;
               idx_d   = idx_q + 2'd1;
               // Snapshot once per scan so a scan never mixes old and new digits.
               capture = (idx_q == 2'd3);
            end
         end
         default: begin
            state_d = StBlank;
            cnt_d   = '0;
         end
      endcase
   end

   // Suppression ripples down from the most significant digit; digit 0 is always shown.
   always_comb begin
      supp    = 4'b0000;
      supp[3] = snap_lz_q && (snap_value_q[15:12] == 4'h0);
      supp[2] = supp[3] && (snap_value_q[11:8] == 4'h0);
      supp[1] = supp[2] && (snap_value_q[7:4] == 4'h0);
   end

   always_comb begin
      lit   = (state_q == StOn) && snap_en_q[idx_q] && !supp[idx_q];
      hex_o = snap_value_q[{idx_q, 2'b00} +: 4];
      an_o  = lit ? ~(4'b0001 << idx_q) : 4'b1111;
      dp_o  = lit ? ~snap_dp_q[idx_q] : 1'b1;
      idx_o = idx_q;
   end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan (ON=4, BLANK=2): stimulus pushes per-cycle expectations
// for each scan, a negedge monitor pops and compares them against the outputs.
module tb_seg_scan;

   logic        clk;
   logic        rst;
   logic [15:0] value;
   logic [3:0]  digit_en;
   logic [3:0]  dp_in;
   logic        lz;
   logic [3:0]  hex;
   logic [3:0]  an;
   logic        dp_out;
   logic [1:0]  idx;

   int checks = 0;
   int errors = 0;
   logic mon_on = 1'b0;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] hex;
      logic       dp;
      logic [1:0] idx;
   } exp_t;

   exp_t exp_q[$];

   // Per-scan stimulus with hand-derived lit-digit and dp-low masks.
   typedef struct {
      logic [15:0] value;
      logic [3:0]  en;
      logic [3:0]  dp;
      logic        lz;
      logic [3:0]  lit;
      logic [3:0]  dpl;
   } cfg_t;

   cfg_t cfgs[9];

   seg_scan #(
      .ON_CYCLES   (4),
      .BLANK_CYCLES(2)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .value_i   (value),
      .digit_en_i(digit_en),
      .dp_i      (dp_in),
      .lz_i      (lz),
      .hex_o     (hex),
      .an_o      (an),
      .dp_o      (dp_out),
      .idx_o     (idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic push_blank_init();
      exp_t e;
      e.an = 4'hF; e.hex = 4'h0; e.dp = 1'b1; e.idx = 2'd3;
      exp_q.push_back(e);
   endtask

   task automatic push_scan(input cfg_t c);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         e.hex = c.value[4*k +: 4];
         e.idx = 2'(k);
         e.an  = c.lit[k] ? ~(4'b0001 << k) : 4'hF;
         e.dp  = ~c.dpl[k];
         repeat (4) exp_q.push_back(e);
         e.an = 4'hF;
         e.dp = 1'b1;
         repeat (2) exp_q.push_back(e);
      end
   endtask

   task automatic apply(input cfg_t c);
      value    = c.value;
      digit_en = c.en;
      dp_in    = c.dp;
      lz       = c.lz;
   endtask

   task automatic check_reset_outputs(input string tag);
      check4({tag, "_an"}, an, 4'hF);
      check4({tag, "_dp"}, {3'b000, dp_out}, 4'h1);
      check4({tag, "_hex"}, hex, 4'h0);
      check4({tag, "_idx"}, {2'b00, idx}, 4'h3);
   endtask

   always @(negedge clk) begin
      if (mon_on && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (an !== e.an || hex !== e.hex || dp_out !== e.dp || idx !== e.idx) begin
            errors++;
            $display("FAIL scan_sample @%0t: an=%b hex=%h dp=%b idx=%0d, expected an=%b hex=%h dp=%b idx=%0d",
                     $time, an, hex, dp_out, idx, e.an, e.hex, e.dp, e.idx);
         end
      end
   end

   initial begin
      //             value     en     dp      lz    lit     dpl
      cfgs[0] = '{16'h1234, 4'hF, 4'b0000, 1'b0, 4'b1111, 4'b0000};
      cfgs[1] = '{16'h1234, 4'hF, 4'b0000, 1'b0, 4'b1111, 4'b0000};
      cfgs[2] = '{16'hABCD, 4'hF, 4'b0000, 1'b0, 4'b1111, 4'b0000};
      cfgs[3] = '{16'h0050, 4'hF, 4'b0000, 1'b1, 4'b0011, 4'b0000};
      cfgs[4] = '{16'h0000, 4'hF, 4'b0000, 1'b1, 4'b0001, 4'b0000};
      cfgs[5] = '{16'h1234, 4'b1011, 4'b0100, 1'b0, 4'b1011, 4'b0000};
      cfgs[6] = '{16'h1234, 4'hF, 4'b0100, 1'b0, 4'b1111, 4'b0100};
      cfgs[7] = '{16'h0F00, 4'hF, 4'b1001, 1'b1, 4'b0111, 4'b0001};
      cfgs[8] = '{16'h0000, 4'hF, 4'b0000, 1'b0, 4'b1111, 4'b0000};

      rst = 1'b1;
      apply(cfgs[0]);
      wait_neg(3);
      check_reset_outputs("reset");

      // Release; outputs stay dark for the BLANK interval before digit 0 is captured.
      rst = 1'b0;
      push_blank_init();
      push_scan(cfgs[0]);
      mon_on = 1'b1;

      // New inputs land while digit 1 is shown; they take effect at the next scan.
      for (int j = 1; j < 9; j++) begin
         wait_neg((j == 1) ? 10 : 24);
         apply(cfgs[j]);
         push_scan(cfgs[j]);
      end

      // Land in the second cycle of digit 0's ON slot of the following scan.
      wait_neg(41);
      mon_on = 1'b0;
      check4("pre_reset_an", an, 4'hE);
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      apply(cfgs[0]);
      wait_neg(2);
      check_reset_outputs("held_reset");

      rst = 1'b0;
      push_blank_init();
      push_scan(cfgs[0]);
      mon_on = 1'b1;
      wait_neg(26);
      mon_on = 1'b0;
      check4("queue_drained", 4'(exp_q.size()), 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
